// File: rtl/exu_alu_arb.sv
// rtl/exu_alu_arb.sv - two-requester round-robin arbiter for a shared ALU
// Tracks the issue stage (E) and a one-entry response buffer (R).
module exu_alu_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             flush,
  input  logic             req0_valid,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic             alu_valid,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [31:0]      alu_out,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  input  logic             rsp_ready
);

  logic             e_v;
  logic             e_id;
  logic [TAG_W-1:0] e_tag;
  logic             last_grant;

  logic rsp_pop, r_free, e_adv, grant_ok, grant, pick;

  assign rsp_pop  = rsp_valid & rsp_ready;
  assign r_free   = ~rsp_valid | rsp_pop;
  assign e_adv    = e_v & r_free;
  // rst_l gating keeps every grant output quiet while reset is held
  assign grant_ok = rst_l & ~freeze & ~flush & (~e_v | r_free);
  assign grant    = grant_ok & (req0_valid | req1_valid);

  // On a tie the requester that did not win last time goes next
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) pick = ~last_grant;
    else                          pick = req1_valid;
  end

  assign req0_ready = grant & ~pick;
  assign req1_ready = grant & pick;
  assign alu_valid  = grant;

  always_comb begin
    alu_a = 32'd0;
    alu_b = 32'd0;
    if (grant) begin
      alu_a = pick ? req1_a : req0_a;
      alu_b = pick ? req1_b : req0_b;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      e_v        <= 1'b0;
      e_id       <= 1'b0;
      e_tag      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_data   <= 32'd0;
      last_grant <= 1'b1;
    end else if (flush) begin
      e_v       <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      if (e_adv) begin
        rsp_valid <= 1'b1;
        rsp_id    <= e_id;
        rsp_tag   <= e_tag;
        rsp_data  <= alu_out;
      end else if (rsp_pop) begin
        rsp_valid <= 1'b0;
      end

      if (grant) begin
        e_v        <= 1'b1;
        e_id       <= pick;
        e_tag      <= pick ? req1_tag : req0_tag;
        last_grant <= pick;
      end else if (e_adv) begin
        e_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exu_alu_arb.sv
// tb/tb_exu_alu_arb.sv - directed vector bench for exu_alu_arb
// The shared ALU is modelled as operand flops feeding an adder.
module tb_exu_alu_arb;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             freeze = 1'b0, flush = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
  logic             req0_ready, req1_ready, alu_valid;
  logic [31:0]      alu_a, alu_b, alu_out;
  logic             rsp_valid, rsp_id, rsp_ready = 1'b0;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic [31:0]      op_a = '0, op_b = '0;

  always #5 clk = ~clk;

  always @(posedge clk) if (alu_valid) begin
    op_a <= alu_a;
    op_b <= alu_b;
  end
  assign alu_out = op_a + op_b;

  exu_alu_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_l(rst_l), .freeze(freeze), .flush(flush),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag), .req1_ready(req1_ready),
    .alu_valid(alu_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .rsp_ready(rsp_ready)
  );

  typedef struct {
    logic        v0, v1, rr, frz, fl;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  t0, t1;
    logic        er0, er1, erv, eid;
    logic [31:0] ea, eb, edata;
    logic [3:0]  etag;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic v0, input int a0, b0, t0, input logic v1, input int a1, b1, t1,
                     input logic rr, frz, fl, input logic er0, er1, input int ea, eb,
                     input logic erv, eid, input int etag, edata);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.b0 = b0; v.t0 = t0[3:0];
    v.v1 = v1; v.a1 = a1; v.b1 = b1; v.t1 = t1[3:0];
    v.rr = rr; v.frz = frz; v.fl = fl;
    v.er0 = er0; v.er1 = er1; v.ea = ea; v.eb = eb;
    v.erv = erv; v.eid = eid; v.etag = etag[3:0]; v.edata = edata;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // idle row shorthand: 0,0,0,0, 0,0,0,0
    add(1,1,2,1,     1,10,20,2,  1,0,0, 1,0,1,2,     0,0,0,0);
    add(1,1,2,1,     1,10,20,2,  1,0,0, 0,1,10,20,   0,0,0,0);
    add(1,1,2,1,     1,10,20,2,  1,0,0, 1,0,1,2,     1,0,1,3);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     1,1,2,30);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     1,0,1,3);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    add(1,5,7,3,     0,0,0,0,    1,0,0, 1,0,5,7,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     1,0,3,12);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    // backpressure into BOTH, then drain
    add(1,100,1,4,   1,200,2,5,  0,0,0, 0,1,200,2,   0,0,0,0);
    add(1,100,1,4,   1,200,2,5,  0,0,0, 1,0,100,1,   0,0,0,0);
    add(1,100,1,4,   1,200,2,5,  0,0,0, 0,0,0,0,     1,1,5,202);
    add(1,100,1,4,   1,200,2,5,  0,0,0, 0,0,0,0,     1,1,5,202);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     1,1,5,202);
    add(1,100,1,4,   1,7,8,6,    1,0,0, 0,1,7,8,     1,0,4,101);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     1,1,6,15);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    // freeze with R full: R drains, no grants until unfrozen
    add(1,2,3,7,     0,0,0,0,    0,0,0, 1,0,2,3,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    0,0,0, 0,0,0,0,     0,0,0,0);
    add(1,4,4,8,     1,6,6,9,    1,1,0, 0,0,0,0,     1,0,7,5);
    add(1,4,4,8,     1,6,6,9,    1,1,0, 0,0,0,0,     0,0,0,0);
    add(1,4,4,8,     1,6,6,9,    1,1,0, 0,0,0,0,     0,0,0,0);
    add(1,4,4,8,     1,6,6,9,    1,0,0, 0,1,6,6,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     1,1,9,12);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    // flush one cycle after a grant kills it
    add(1,1,1,10,    1,3,3,11,   1,0,0, 1,0,1,1,     0,0,0,0);
    add(1,1,1,10,    1,3,3,11,   1,0,1, 0,0,0,0,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    add(1,1,1,10,    1,3,3,11,   1,0,0, 0,1,3,3,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     1,1,11,6);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    // flush in BOTH overrides pop and grant
    add(1,9,9,12,    0,0,0,0,    0,0,0, 1,0,9,9,     0,0,0,0);
    add(0,0,0,0,     1,1,1,13,   0,0,0, 0,1,1,1,     0,0,0,0);
    add(1,2,2,14,    0,0,0,0,    1,0,1, 0,0,0,0,     1,0,12,18);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);
    add(0,0,0,0,     0,0,0,0,    1,0,0, 0,0,0,0,     0,0,0,0);

    // reset state with requests pending
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #3;
    chk("rst req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst alu_valid",  {31'd0, alu_valid},  32'd0);
    chk("rst alu_a",      alu_a,               32'd0);
    chk("rst alu_b",      alu_b,               32'd0);
    chk("rst rsp_valid",  {31'd0, rsp_valid},  32'd0);
    chk("rst rsp_id",     {31'd0, rsp_id},     32'd0);
    chk("rst rsp_tag",    {28'd0, rsp_tag},    32'd0);
    chk("rst rsp_data",   rsp_data,            32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0; req0_tag = vecs[i].t0;
      req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1; req1_tag = vecs[i].t1;
      rsp_ready = vecs[i].rr; freeze = vecs[i].frz; flush = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("v%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].er0});
      chk($sformatf("v%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].er1});
      chk($sformatf("v%0d alu_valid", i),  {31'd0, alu_valid},  {31'd0, vecs[i].er0 | vecs[i].er1});
      chk($sformatf("v%0d alu_a", i),      alu_a,               vecs[i].ea);
      chk($sformatf("v%0d alu_b", i),      alu_b,               vecs[i].eb);
      chk($sformatf("v%0d rsp_valid", i),  {31'd0, rsp_valid},  {31'd0, vecs[i].erv});
      if (vecs[i].erv) begin
        chk($sformatf("v%0d rsp_id", i),   {31'd0, rsp_id},     {31'd0, vecs[i].eid});
        chk($sformatf("v%0d rsp_tag", i),  {28'd0, rsp_tag},    {28'd0, vecs[i].etag});
        chk($sformatf("v%0d rsp_data", i), rsp_data,            vecs[i].edata);
      end
    end

    // reset asserted while in BOTH
    @(posedge clk); #1;
    flush = 1'b0; freeze = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 3; req0_b = 4; req0_tag = 1; req1_valid = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 5; req1_b = 5; req1_tag = 2;
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("both rsp_valid",  {31'd0, rsp_valid},  32'd1);
    chk("both rsp_data",   rsp_data,            32'd7);
    chk("both req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("both req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("both alu_valid",  {31'd0, alu_valid},  32'd0);
    rst_l = 1'b0;
    #1;
    chk("mid rst rsp_valid",  {31'd0, rsp_valid},  32'd0);
    chk("mid rst req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("mid rst req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("mid rst alu_valid",  {31'd0, alu_valid},  32'd0);
    chk("mid rst alu_a",      alu_a,               32'd0);
    chk("mid rst rsp_data",   rsp_data,            32'd0);
    rsp_ready = 1'b1; req0_a = 20; req0_b = 1; req0_tag = 3;
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    chk("post rst req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("post rst req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("post rst alu_a",      alu_a,               32'd20);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("post rst no stale rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("post rst rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("post rst rsp_id",    {31'd0, rsp_id},    32'd0);
    chk("post rst rsp_tag",   {28'd0, rsp_tag},   32'd3);
    chk("post rst rsp_data",  rsp_data,           32'd21);
    @(negedge clk);
    chk("post rst drained", {31'd0, rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/exu_alu_arb.md
EXU_ALU_ARB -- requirements
Module: exu_alu_arb

Interface
REQ-001 Parameter: TAG_W, default 4, width of the per-request tag returned with each result.
REQ-002 clk  input  1  top-level clock; all state on its rising edge.
REQ-003 rst_l  input  1  reset, asynchronous assert, active-low.
REQ-004 freeze  input  1  pipeline freeze; blocks new grants.
REQ-005 flush  input  1  pipeline flush; kills in-flight and buffered work.
REQ-006 req0_valid / req1_valid  input  1  requester k has an operation pending.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  32  operands of requester k.
REQ-008 req0_tag / req1_tag  input  TAG_W  tag of requester k.
REQ-009 req0_ready / req1_ready  output  1  grant; the operation is taken on a cycle with valid & ready.
REQ-010 alu_valid  output  1  drives the shared ALU operand-flop enable; high only on a grant cycle.
REQ-011 alu_a, alu_b  output  32  operands of the granted requester; 0 when alu_valid=0.
REQ-012 alu_out  input  32  shared ALU result, valid the cycle after alu_valid.
REQ-013 rsp_valid  output  1  response buffer holds a result.
REQ-014 rsp_id  output  1  requester of the buffered result (0/1).
REQ-015 rsp_tag  output  TAG_W  tag of the buffered result.
REQ-016 rsp_data  output  32  buffered result.
REQ-017 rsp_ready  input  1  consumer accepts the response on rsp_valid & rsp_ready.

Function
REQ-018 Two-stage occupancy: E (operation issued, result on alu_out this cycle) and R (response buffer); states IDLE(E0,R0), ISSUED(E1,R0), RESP(E0,R1), BOTH(E1,R1).
REQ-019 rsp_pop = rsp_valid & rsp_ready; r_free = ~R_v | rsp_pop; e_adv = E_v & r_free.
REQ-020 grant_ok = ~freeze & ~flush & (~E_v | r_free).
REQ-021 On e_adv, R captures {alu_out, E id, E tag} at the clock edge; R_v clears on rsp_pop without e_adv.
REQ-022 On a grant, E_v sets with the granted id/tag; E_v clears on e_adv without a new grant; E holds when ~r_free.
REQ-023 Only one of req0_ready/req1_ready is ever high; ready is high only for a valid requester when grant_ok.
REQ-024 Single valid requester is granted; both valid: grant the requester other than last_grant.
REQ-025 last_grant updates to the granted id on every grant, otherwise holds.
REQ-026 Latency: grant in cycle N -> rsp_valid in N+2 when R is free; back-to-back grants sustain 1 result/cycle with rsp_ready=1.
REQ-027 Backpressure: with BOTH and rsp_ready=0, no grants; alu_valid=0 so alu_out stays stable for the held E.
REQ-028 freeze blocks grants only; E->R advance and rsp_pop continue during freeze.
REQ-029 flush: no grant that cycle; E_v and R_v clear at the edge; rsp_valid=0 the next cycle; last_grant unchanged; flush overrides simultaneous rsp_pop and grant.
REQ-030 Requesters hold valid, operands and tag stable until ready; the block does not buffer unaccepted requests.

Reset
REQ-031 On rst_l low, asynchronously: E_v=0, R_v=0, last_grant=1 (req0 wins first tie), rsp_id=0, rsp_tag=0, rsp_data=0.
REQ-032 During reset all ready outputs, alu_valid and rsp_valid are 0; alu_a/alu_b are 0.
REQ-033 Reset asserted mid-operation discards E and R contents; no response is emitted after reset release for pre-reset grants.

Verification
REQ-034 Reset release, both valid, tags 1/2, rsp_ready=1 -> grants req0, req1, req0 on consecutive cycles; responses id 0,1,0 with tags 1,2,1 beginning two cycles after the first grant.
REQ-035 req0 only, a=5 b=7, ALU returns 12 -> rsp_valid two cycles after grant, rsp_data=12, rsp_id=0.
REQ-036 rsp_ready=0 with two grants issued -> state BOTH, third request not readied, alu_valid=0; rsp_ready=1 -> both results drain in order, one per cycle, then grants resume.
REQ-037 flush in the cycle after a grant -> no response ever appears for it; rsp_valid=0; next tie goes to the requester not last granted.
REQ-038 freeze=1 for 3 cycles with R full and rsp_ready=1 -> R drains, no grants during freeze, grant on the first unfrozen cycle.
REQ-039 rst_l asserted while in BOTH -> all valid/ready outputs 0 immediately; after release, req1 and req0 both valid -> req0 granted first.
